dcm_rst_ctrl: RTL



---
 rtl/dcm_rst_ctrl_pkg.sv | 27 ++
 rtl/dcm_rst_ctrl_if.sv | 22 ++
 rtl/dcm_rst_ctrl_lock_sync.sv | 16 +
 rtl/dcm_rst_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dcm_rst_ctrl_pkg.sv
// Shared types and widths for the DCM reset sequencer.
// Optional build macro used by this block: DCM_LOCK_FILTER_EN.
package dcm_rst_ctrl_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned RETRY_W   = 4;
  localparam int unsigned RETRY_MAX = 15;

  typedef enum logic [STATE_W-1:0] {
    ST_RST_DCM   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Largest of three cycle counts; sizes the shared cycle counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/dcm_rst_ctrl_if.sv
// DCM lock/reset interface: the sequencer (master) drives resets and status,
// the DCM side (slave) supplies LOCKED.
interface dcm_rst_ctrl_if;
  import dcm_rst_ctrl_pkg::*;

  logic               locked_in;
  logic               dcm_rst;
  logic               chip_rst;
  logic [RETRY_W-1:0] retry_cnt;
  logic               fail;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  locked_in,
    output dcm_rst, chip_rst, retry_cnt, fail, state_o
  );

  modport slave (
    output locked_in,
    input  dcm_rst, chip_rst, retry_cnt, fail, state_o
  );
endinterface

// File: rtl/dcm_rst_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous DCM LOCKED into the clk domain.
module lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];
endmodule

// File: rtl/dcm_rst_ctrl.sv
// DCM reset sequencer: pulses dcm_rst, waits for lock with timeout/retries,
// settles, then releases chip_rst. DCM_LOCK_FILTER_EN debounces lock loss in RUN.
module dcm_rst_ctrl
  import dcm_rst_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT     = 65535,
  parameter int unsigned SETTLE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRIES      = 7
) (
  input  logic          clk,
  input  logic          reset,
  dcm_rst_ctrl_if.master bus
);

  localparam int unsigned CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               dcm_rst_q, chip_rst_q, fail_q;
  logic               locked_s;
  logic               lock_lost_c;

  lock_sync u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.locked_in),
    .q     (locked_s)
  );

`ifdef DCM_LOCK_FILTER_EN
  localparam int unsigned FILT_LEN = 4;

  logic [1:0] filt_q, filt_d;

  // Lock counts as lost only on the FILT_LEN-th consecutive low cycle in RUN.
  always_comb begin
    filt_d      = 2'b00;
    lock_lost_c = 1'b0;
    if (state_q == ST_RUN && !locked_s) begin
      if (filt_q == 2'(FILT_LEN - 1)) lock_lost_c = 1'b1;
      else                            filt_d      = filt_q + 2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) filt_q <= 2'b00;
    else       filt_q <= filt_d;
  end
`else
  assign lock_lost_c = !locked_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST_DCM;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_RST_DCM: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          retry_d = (retry_q == RETRY_W'(RETRY_MAX)) ? retry_q : retry_q + RETRY_W'(1);
          state_d = (retry_q == RETRY_W'(MAX_RETRIES - 1)) ? ST_FAIL : ST_RST_DCM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_d = ST_RST_DCM;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (lock_lost_c) begin
          state_d = ST_RST_DCM;
          retry_d = '0;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RST_DCM;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they are glitch-free and track state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcm_rst_q  <= 1'b1;
      chip_rst_q <= 1'b1;
      fail_q     <= 1'b0;
    end else begin
      dcm_rst_q  <= (state_d == ST_RST_DCM) || (state_d == ST_FAIL);
      chip_rst_q <= (state_d != ST_RUN);
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  assign bus.dcm_rst   = dcm_rst_q;
  assign bus.chip_rst  = chip_rst_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_o   = state_q;

endmodule
